// File: rtl/song_reader.sv
// song_reader
//   Walks the note list of the selected song in an external registered song
//   ROM and hands one note at a time to the note player.
//   Ports:
//     clk          system clock
//     reset        sync active-high global reset
//     reset_player sync active-high restart from the mcu (same effect as reset)
//     play         1 = run, 0 = pause (only stalls between notes)
//     song         selected song, latched on reset/reset_player only
//     rom_addr     {song_q, idx} to the song ROM
//     rom_data     {note, duration}, valid one cycle after rom_addr
//     note_done    pulse from the note player: current note finished
//     note         current note code (0 = rest), registered
//     duration     current duration, registered
//     new_note     one-cycle pulse: note/duration are new and valid
//     song_done    one-cycle pulse to the mcu: song finished
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_player,
  input  logic                      play,
  input  logic [1:0]                song,
  output logic [IDX_W+1:0]          rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  input  logic                      note_done,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  output logic                      song_done
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT_ROM,
    S_EMIT,
    S_PLAYING,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_song_q;
  logic [IDX_W-1:0]    r_idx;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_duration;
  logic                r_new_note;
  logic                r_song_done;

  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;

  assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur  = rom_data[DUR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset || reset_player) begin
      r_state     <= S_FETCH;
      r_idx       <= '0;
      r_note      <= '0;
      r_duration  <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
      r_song_q    <= song;
    end else begin
      // Pulses are asserted on the transition into EMIT/DONE and cleared on
      // every other edge, so each lasts exactly one cycle.
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (play) r_state <= S_WAIT_ROM;
        end
        S_WAIT_ROM: begin
          if (w_rom_dur == '0) begin
            r_state     <= S_DONE;
            r_song_done <= 1'b1;
            r_note      <= '0;
            r_duration  <= '0;
          end else begin
            r_state    <= S_EMIT;
            r_new_note <= 1'b1;
            r_note     <= w_rom_note;
            r_duration <= w_rom_dur;
          end
        end
        S_EMIT: begin
          r_state <= S_PLAYING;
        end
        S_PLAYING: begin
          if (note_done) begin
            // The last slot ends the song; idx never wraps.
            if (r_idx == '1) begin
              r_state     <= S_DONE;
              r_song_done <= 1'b1;
              r_note      <= '0;
              r_duration  <= '0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign rom_addr  = {r_song_q, r_idx};
  assign note      = r_note;
  assign duration  = r_duration;
  assign new_note  = r_new_note;
  assign song_done = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        reset_player;
  logic        play;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic        note_done;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned nn_cnt;
  int unsigned sd_cnt;
  logic        both_seen;

  logic [11:0] rom [0:127];

  song_reader #(.NOTE_W(6), .DUR_W(6), .IDX_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .reset_player (reset_player),
    .play         (play),
    .song         (song),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note_done    (note_done),
    .note         (note),
    .duration     (duration),
    .new_note     (new_note),
    .song_done    (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered song ROM, one cycle latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (new_note) nn_cnt++;
    if (song_done) sd_cnt++;
    if (new_note && song_done) both_seen = 1'b1;
  endtask

  // Wait for new_note with a bound; returns number of ticks taken.
  task automatic wait_note(output int unsigned waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!new_note && waited < 10);
  endtask

  initial begin
    int unsigned w;
    int unsigned nn_ref;
    int unsigned sd_ref;
    n_checks = 0; n_fail = 0; nn_cnt = 0; sd_cnt = 0; both_seen = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 12'h000;
    for (int i = 0; i < 32; i++) rom[i] = {6'd7, 6'd7};
    rom[32] = {6'd12, 6'd8};
    rom[33] = {6'd20, 6'd5};
    rom[34] = {6'd9,  6'd0};
    for (int i = 0; i < 32; i++) rom[64+i] = {6'(i+1), 6'(i+3)};

    reset = 1'b1; reset_player = 1'b0; play = 1'b0; song = 2'd0; note_done = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // 1: paused after reset
    for (int i = 0; i < 20; i++) tick();
    check("t1_nn_cnt", nn_cnt, 0);
    check("t1_addr", rom_addr, 0);
    check("t1_note", note, 0);
    check("t1_dur", duration, 0);
    check("t1_new_note", new_note, 0);
    check("t1_song_done", song_done, 0);

    // 2: select song 1, first note two cycles after play
    song = 2'd1; reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    tick();
    check("t2_addr", rom_addr, 32);
    play = 1'b1;
    tick();
    check("t2_nn_early", new_note, 0);
    tick();
    check("t2_nn", new_note, 1);
    check("t2_note", note, 12);
    check("t2_dur", duration, 8);

    // 3: note_done while paused -> hold in FETCH
    play = 1'b0;
    tick();
    check("t3_nn_off", new_note, 0);
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    check("t3_addr", rom_addr, 33);
    check("t3_note_hold", note, 12);
    nn_ref = nn_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("t3_paused_nn", nn_cnt, nn_ref);
    check("t3_dur_hold", duration, 8);
    play = 1'b1;
    tick();
    check("t3_nn_early", new_note, 0);
    tick();
    check("t3_nn", new_note, 1);
    check("t3_note", note, 20);
    check("t3_dur", duration, 5);

    // 4: duration-0 marker ends the song
    tick();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    tick();
    check("t4_sd_early", song_done, 0);
    tick();
    check("t4_sd", song_done, 1);
    check("t4_nn", new_note, 0);
    check("t4_note", note, 0);
    check("t4_dur", duration, 0);
    tick();
    check("t4_sd_pulse", song_done, 0);
    nn_ref = nn_cnt; sd_ref = sd_cnt;
    for (int i = 0; i < 10; i++) begin
      note_done = i[0];
      play = i[1];
      tick();
    end
    note_done = 1'b0;
    check("t4_idle_nn", nn_cnt, nn_ref);
    check("t4_idle_sd", sd_cnt, sd_ref);
    check("t4_addr", rom_addr, 34);

    // 5: reset_player in PLAYING with note_done, song change to 2
    play = 1'b0; reset_player = 1'b1;
    tick();
    reset_player = 1'b0; play = 1'b1;
    wait_note(w);
    check("t5_lat", w, 2);
    check("t5_note", note, 12);
    tick();
    sd_ref = sd_cnt;
    song = 2'd2; reset_player = 1'b1; note_done = 1'b1; play = 1'b0;
    tick();
    reset_player = 1'b0; note_done = 1'b0;
    check("t5_addr", rom_addr, 64);
    check("t5_note", note, 0);
    check("t5_dur", duration, 0);
    check("t5_nn", new_note, 0);
    for (int i = 0; i < 3; i++) tick();
    check("t5_sd_cnt", sd_cnt, sd_ref);
    check("t5_addr_hold", rom_addr, 64);

    // 6: full 32-entry song without end marker
    nn_ref = nn_cnt;
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_note(w);
      check("t6_lat", w, 2);
      check("t6_note", note, i + 1);
      check("t6_dur", duration, i + 3);
      tick();
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
      if (i == 31) begin
        check("t6_sd", song_done, 1);
        check("t6_note_done", note, 0);
      end
    end
    check("t6_nn_total", nn_cnt - nn_ref, 32);
    check("t6_addr", rom_addr, 95);
    tick();
    check("t6_sd_pulse", song_done, 0);
    tick(); tick();
    check("t6_addr_hold", rom_addr, 95);
    check("excl_pulses", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
